hms_set_ctrl: RTL and testbench
===============================

// Module: hms_set_ctrl
// PURPOSE
//  Time-set controller that sequences timer_hms_top and configures seg7 for the 00HHMMSS clock display.
//  Three push buttons (mode/inc/dec) are synchronised, debounced and edge-detected.
//  - In RUN the timer counts.
//  - In SET_HH/SET_MM/SET_SS the timer is halted and the selected field blinks.
//  - inc/dec edit the selected field in BCD; the edited value is loaded back into the timer on exit.
//  Drives aen/dp_en into seg7; sits between the board buttons and timer_hms_top.
// PARAMETERS
//  DEBOUNCE_CYC  2_000_000    consecutive stable cycles before a debounced level changes (20 ms @100 MHz)
//  BLINK_CYC     25_000_000   cycles per blink phase (2 Hz toggle)
//  TIMEOUT_CYC   1_000_000_000  idle cycles in a SET state before abandoning the edit (10 s)
// PORTS
//  clk_100m   in   1   system clock, 100 MHz
//  rst_n      in   1   asynchronous active-low reset
//  btn_mode   in   1   raw mode button, active high, asynchronous to clk_100m
//  btn_inc    in   1   raw increment button, active high
//  btn_dec    in   1   raw decrement button, active high
//  cur_hms    in   32  live timer value, BCD 00HHMMSS
//  timer_run  out  1   timer count enable
//  load_en    out  1   one-cycle load strobe to timer
//  load_hms   out  32  value to load, BCD 00HHMMSS, valid when load_en=1
//  aen        out  8   digit enables to seg7 (bit0 = seconds units)
//  dp_en      out  8   decimal-point enables to seg7
// BEHAVIOUR
//  Reset values: state=RUN, timer_run=1, load_en=0, load_hms=32'h0, aen=8'h3F, dp_en=8'h14,
//  blink phase=1 (visible), all counters 0, debounced levels 0.
//  Button path, per button:
//  - 2-FF synchroniser, then debounce counter.
//  - Counter clears whenever the synced input equals the debounced level.
//  - The debounced level flips when the counter reaches DEBOUNCE_CYC-1.
//  - A press event is a 1-cycle pulse on the debounced 0->1 edge.
//  - Latency from a stable raw edge to the press pulse: 2 + DEBOUNCE_CYC cycles.
//  FSM RUN -> SET_HH -> SET_MM -> SET_SS -> RUN, advancing on each mode press:
//  - RUN->SET_HH: edit <= cur_hms that cycle; timer_run=0 from the next cycle.
//  - SET_SS->RUN on mode: load_en=1 for exactly 1 cycle, load_hms=edit with [31:24]=8'h00;
//    timer_run=1 from the cycle after load_en.
//  - Timeout: in any SET state, TIMEOUT_CYC cycles with no press event -> RUN, no load_en, edit discarded.
//    Any press event clears the timeout counter.
//  - inc/dec presses in RUN are ignored.
//  Edit arithmetic (BCD, selected field only):
//  - HH wraps 23->00 on inc and 00->23 on dec.
//  - MM and SS wrap 59->00 on inc and 00->59 on dec.
//  - Units 9 carries into tens (09->10); dec 10->09.
//  - A field holding invalid BCD or an out-of-range value becomes 00 on the next inc or dec.
//  Simultaneous events:
//  - mode together with inc/dec: mode wins, inc/dec dropped.
//  - inc and dec together: both ignored.
//  Blink:
//  - Blink counter runs only in SET states; phase toggles every BLINK_CYC cycles.
//  - On entry to a SET state and on any inc/dec press: phase=1 and counter=0.
//  Display outputs:
//  - aen[7:6] is always 0 (leading 00 is blanked).
//  - aen[5:4]=HH, [3:2]=MM, [1:0]=SS.
//  - In a SET state with phase=0, the selected pair is cleared; otherwise aen=8'h3F.
//  - dp_en is fixed at 8'h14 (separators after HH and MM).
//  All outputs are registered.
//  Reset mid-edit: edit discarded, no load_en, state RUN.
// STRUCTURE
//  Shared package hms_pkg holds:
//  - state encoding (RUN, SET_HH, SET_MM, SET_SS);
//  - BCD limits HH_MAX=8'h23, MS_MAX=8'h59;
//  - field bit offsets and the aen pair masks;
//  - DP_SEPARATORS=8'h14.
//  Sub-module btn_debounce (sync + debounce + rise pulse, parameter DEBOUNCE_CYC), instantiated 3 times.
//  FSM, BCD edit, blink and timeout logic stay in hms_set_ctrl.
// TESTING (bench uses DEBOUNCE_CYC=4, BLINK_CYC=8, TIMEOUT_CYC=200)
//  1. Reset, then idle -> timer_run=1, aen=8'h3F, dp_en=8'h14, load_en=0.
//  2. cur_hms=32'h00235958; mode, inc on HH; mode, inc on MM; mode, inc on SS; mode
//     -> single load_en pulse with load_hms=32'h00000059; timer_run low throughout the edit, high after.
//  3. Bounce: btn_inc toggled every 2 cycles for 20 cycles, then held high -> exactly one press;
//     a 3-cycle glitch -> no press.
//  4. In SET_MM, leave buttons idle -> aen alternates 8'h3F / 8'h33 every 8 cycles.
//     dec on edit MM=00 -> MM=59 with aen forced to 8'h3F.
//  5. mode and inc pressed in the same cycle in SET_HH -> state SET_MM, HH unchanged.
//     inc and dec in the same cycle -> no change.
//  6. Enter SET_HH, idle 200 cycles -> RUN with no load_en.
//     Separately, assert rst_n=0 mid-edit -> reset values, no load_en.

Source files
------------

// File: rtl/hms_pkg.sv
// Shared definitions for the HH:MM:SS time-set controller: state encoding,
// BCD field limits, display masks and the BCD field step helper.
package hms_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } state_t;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  localparam int unsigned HH_LSB = 16;
  localparam int unsigned MM_LSB = 8;
  localparam int unsigned SS_LSB = 0;

  localparam logic [7:0] AEN_ALL = 8'h3F;
  localparam logic [7:0] AEN_HH  = 8'h30;
  localparam logic [7:0] AEN_MM  = 8'h0C;
  localparam logic [7:0] AEN_SS  = 8'h03;

  localparam logic [7:0] DP_SEPARATORS = 8'h14;

  // One BCD step with wrap; invalid digits or out-of-range values collapse to 00.
  function automatic logic [7:0] bcd_step(input logic [7:0] f, input logic [7:0] lim,
                                          input logic up);
    logic [3:0] hi;
    logic [3:0] lo;
    logic [7:0] r;
    hi = f[7:4];
    lo = f[3:0];
    if (hi > 4'd9 || lo > 4'd9 || f > lim) begin
      r = 8'h00;
    end else if (up) begin
      if (f == lim)        r = 8'h00;
      else if (lo == 4'd9) r = {hi + 4'd1, 4'd0};
      else                 r = {hi, lo + 4'd1};
    end else begin
      if (f == 8'h00)      r = lim;
      else if (lo == 4'd0) r = {hi - 4'd1, 4'd9};
      else                 r = {hi, lo - 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] aen_mask(input state_t s);
    logic [7:0] m;
    case (s)
      SET_HH:  m = AEN_HH;
      SET_MM:  m = AEN_MM;
      SET_SS:  m = AEN_SS;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-count debounce and a
// one-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // Level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_q <= sync_q2;
        press   <= sync_q2;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hms_set_ctrl.sv
// Time-set controller: walks RUN -> SET_HH -> SET_MM -> SET_SS on mode presses,
// edits the selected BCD field, blinks it, and loads the result into the timer.
module hms_set_ctrl
  import hms_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 2_000_000,
  parameter int unsigned BLINK_CYC    = 25_000_000,
  parameter int unsigned TIMEOUT_CYC  = 1_000_000_000
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [31:0] cur_hms,
  output logic        timer_run,
  output logic        load_en,
  output logic [31:0] load_hms,
  output logic [7:0]  aen,
  output logic [7:0]  dp_en
);

  localparam int unsigned BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam int unsigned TMO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

  logic press_mode;
  logic press_inc;
  logic press_dec;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk(clk_100m), .rst_n(rst_n), .btn(btn_mode), .press(press_mode)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk(clk_100m), .rst_n(rst_n), .btn(btn_inc), .press(press_inc)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dec (
    .clk(clk_100m), .rst_n(rst_n), .btn(btn_dec), .press(press_dec)
  );

  state_t             state_q, state_d;
  logic [23:0]        edit_q, edit_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               timer_run_d;
  logic               load_en_d;
  logic [31:0]        load_hms_d;
  logic [7:0]         aen_d;

  // The leading digit pair of the live value is never edited.
  logic unused_cur_hi;
  assign unused_cur_hi = ^cur_hms[31:24];

  always_comb begin
    state_d     = state_q;
    edit_d      = edit_q;
    load_en_d   = 1'b0;
    load_hms_d  = load_hms;
    tmo_cnt_d   = '0;
    blink_cnt_d = '0;
    phase_d     = 1'b1;

    // Mode beats inc/dec; inc with dec cancels; silence advances the timeout.
    if (state_q == RUN) begin
      if (press_mode) begin
        state_d = SET_HH;
        edit_d  = cur_hms[23:0];
      end
    end else if (press_mode) begin
      case (state_q)
        SET_HH:  state_d = SET_MM;
        SET_MM:  state_d = SET_SS;
        default: begin
          state_d    = RUN;
          load_en_d  = 1'b1;
          load_hms_d = {8'h00, edit_q};
        end
      endcase
    end else if (press_inc || press_dec) begin
      if (press_inc ^ press_dec) begin
        case (state_q)
          SET_HH:  edit_d[HH_LSB +: 8] = bcd_step(edit_q[HH_LSB +: 8], HH_MAX, press_inc);
          SET_MM:  edit_d[MM_LSB +: 8] = bcd_step(edit_q[MM_LSB +: 8], MS_MAX, press_inc);
          default: edit_d[SS_LSB +: 8] = bcd_step(edit_q[SS_LSB +: 8], MS_MAX, press_inc);
        endcase
      end
    end else if (tmo_cnt_q == TMO_LAST) begin
      state_d = RUN;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    // Blink restarts visible on field entry or any edit press.
    if (state_d != RUN && state_d == state_q && !press_inc && !press_dec) begin
      if (blink_cnt_q == BLINK_LAST) begin
        phase_d = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        phase_d     = phase_q;
      end
    end

    aen_d       = (state_d != RUN && !phase_d) ? (AEN_ALL & ~aen_mask(state_d)) : AEN_ALL;
    timer_run_d = (state_q == RUN) && (state_d == RUN);
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      edit_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      tmo_cnt_q   <= '0;
      timer_run   <= 1'b1;
      load_en     <= 1'b0;
      load_hms    <= '0;
      aen         <= AEN_ALL;
      dp_en       <= DP_SEPARATORS;
    end else begin
      state_q     <= state_d;
      edit_q      <= edit_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      tmo_cnt_q   <= tmo_cnt_d;
      timer_run   <= timer_run_d;
      load_en     <= load_en_d;
      load_hms    <= load_hms_d;
      aen         <= aen_d;
      dp_en       <= DP_SEPARATORS;
    end
  end

endmodule

// File: tb/tb_hms_set_ctrl.sv
// Bench for hms_set_ctrl: cycle-level behavioural model checked every cycle,
// a table of edit vectors, directed corner sequences and a random phase.
module tb_hms_set_ctrl;

  localparam int unsigned DEB   = 4;
  localparam int unsigned BLINK = 8;
  localparam int unsigned TMO   = 200;

  logic        clk_100m = 1'b0;
  logic        rst_n    = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc  = 1'b0;
  logic        btn_dec  = 1'b0;
  logic [31:0] cur_hms  = 32'h0;
  logic        timer_run;
  logic        load_en;
  logic [31:0] load_hms;
  logic [7:0]  aen;
  logic [7:0]  dp_en;

  always #5 clk_100m = ~clk_100m;

  hms_set_ctrl #(.DEBOUNCE_CYC(DEB), .BLINK_CYC(BLINK), .TIMEOUT_CYC(TMO)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .cur_hms(cur_hms), .timer_run(timer_run), .load_en(load_en),
    .load_hms(load_hms), .aen(aen), .dp_en(dp_en)
  );

  int nvec = 0;
  int nerr = 0;
  int load_cnt = 0;
  logic [31:0] last_load = 32'h0;

  // ---------------- behavioural reference model ----------------
  int         m_mode = 0;              // 0 run, 1 hh, 2 mm, 3 ss
  logic [7:0] m_f [3] = '{8'h0, 8'h0, 8'h0};
  int         m_age = 0;
  int         m_idle = 0;
  bit         m_d1 [3] = '{0, 0, 0};
  bit         m_d2 [3] = '{0, 0, 0};
  bit         m_level [3] = '{0, 0, 0};
  bit         m_press [3] = '{0, 0, 0};
  bit         m_hist [3][$];
  bit         e_run = 1'b1;
  bit         e_load = 1'b0;
  logic [31:0] e_load_hms = 32'h0;
  logic [7:0]  e_aen = 8'h3F;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [7:0] bcd_edit(input logic [7:0] f, input int maxv, input bit up);
    int hi, lo, v;
    hi = int'(f[7:4]);
    lo = int'(f[3:0]);
    if (hi > 9 || lo > 9) return 8'h00;
    v = hi * 10 + lo;
    if (v > maxv) return 8'h00;
    v = up ? (v + 1) % (maxv + 1) : (v + maxv) % (maxv + 1);
    return to_bcd(v);
  endfunction

  always @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_age = 0; m_idle = 0;
      for (int b = 0; b < 3; b++) begin
        m_f[b] = 8'h0; m_d1[b] = 0; m_d2[b] = 0; m_level[b] = 0; m_press[b] = 0;
        m_hist[b].delete();
      end
      e_run = 1; e_load = 0; e_load_hms = 32'h0; e_aen = 8'h3F;
    end else begin
      bit pm, pi, pd, ok, syn;
      bit raw [3];
      int prev;
      pm = m_press[0]; pi = m_press[1]; pd = m_press[2];
      prev = m_mode;
      e_load = 0;
      if (pm) begin
        if (m_mode == 0) begin
          m_f[0] = cur_hms[23:16]; m_f[1] = cur_hms[15:8]; m_f[2] = cur_hms[7:0];
          m_mode = 1; m_age = 0; m_idle = 0;
        end else if (m_mode == 3) begin
          e_load = 1; e_load_hms = {8'h00, m_f[0], m_f[1], m_f[2]}; m_mode = 0;
        end else begin
          m_mode++; m_age = 0; m_idle = 0;
        end
      end else if (m_mode != 0) begin
        if (pi || pd) begin
          m_idle = 0; m_age = 0;
          if (pi != pd) m_f[m_mode-1] = bcd_edit(m_f[m_mode-1], (m_mode == 1) ? 23 : 59, pi);
        end else begin
          m_idle++; m_age++;
          if (m_idle >= int'(TMO)) m_mode = 0;
        end
      end
      e_run = (prev == 0) && (m_mode == 0);
      if (m_mode != 0 && ((m_age / int'(BLINK)) % 2) == 1)
        e_aen = 8'h3F & ~(8'h03 << (2 * (3 - m_mode)));
      else
        e_aen = 8'h3F;
      // Button level changes after DEB consecutive synced samples disagree.
      raw[0] = btn_mode; raw[1] = btn_inc; raw[2] = btn_dec;
      for (int b = 0; b < 3; b++) begin
        syn = m_d2[b]; m_d2[b] = m_d1[b]; m_d1[b] = raw[b];
        m_press[b] = 0;
        m_hist[b].push_back(syn);
        if (m_hist[b].size() > int'(DEB)) void'(m_hist[b].pop_front());
        if (m_hist[b].size() == int'(DEB)) begin
          ok = 1;
          foreach (m_hist[b][j]) if (m_hist[b][j] == m_level[b]) ok = 0;
          if (ok) begin
            m_level[b] = ~m_level[b];
            m_press[b] = m_level[b];
            m_hist[b].delete();
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus load pulse bookkeeping.
  always @(negedge clk_100m) begin
    nvec++;
    if (timer_run !== e_run || load_en !== e_load || aen !== e_aen || dp_en !== 8'h14 ||
        (e_load && load_hms !== e_load_hms)) begin
      nerr++;
      $display("FAIL cycle t=%0t: got run=%b load=%b hms=%h aen=%h dp=%h want run=%b load=%b hms=%h aen=%h dp=14",
               $time, timer_run, load_en, load_hms, aen, dp_en, e_run, e_load, e_load_hms, e_aen);
    end
    if (load_en === 1'b1) begin
      load_cnt++;
      last_load = load_hms;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic press(input bit m, input bit i, input bit d);
    @(negedge clk_100m);
    btn_mode = m; btn_inc = i; btn_dec = d;
    repeat (DEB + 4) @(negedge clk_100m);
    btn_mode = 0; btn_inc = 0; btn_dec = 0;
    repeat (DEB + 4) @(negedge clk_100m);
  endtask

  task automatic wait_aen(input string name, input logic [7:0] v);
    int n;
    n = 0;
    while (aen !== v && n < 40) begin
      @(negedge clk_100m);
      n++;
    end
    check(name, 32'(aen), 32'(v));
  endtask

  task automatic run_len(input logic [7:0] v, output int len);
    len = 0;
    while (aen === v && len < 40) begin
      @(negedge clk_100m);
      len++;
    end
  endtask

  typedef struct {
    logic [31:0] cur;
    int          field;
    bit          up;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0, len;
    tbl[0]  = '{32'h00235958, 0, 1'b1, 32'h00005958};
    tbl[1]  = '{32'h00005958, 0, 1'b0, 32'h00235958};
    tbl[2]  = '{32'h00095958, 0, 1'b1, 32'h00105958};
    tbl[3]  = '{32'h00100000, 0, 1'b0, 32'h00090000};
    tbl[4]  = '{32'h00123456, 1, 1'b1, 32'h00123556};
    tbl[5]  = '{32'h00125956, 1, 1'b1, 32'h00120056};
    tbl[6]  = '{32'h00120056, 1, 1'b0, 32'h00125956};
    tbl[7]  = '{32'h0012345A, 2, 1'b1, 32'h00123400};
    tbl[8]  = '{32'h00126034, 1, 1'b0, 32'h00120034};
    tbl[9]  = '{32'h00250000, 0, 1'b1, 32'h00000000};
    tbl[10] = '{32'hAB123456, 2, 1'b0, 32'h00123455};
    tbl[11] = '{32'h00121209, 2, 1'b1, 32'h00121210};

    repeat (3) @(negedge clk_100m);
    #2 rst_n = 1'b1;

    // Idle after reset.
    repeat (10) @(negedge clk_100m);
    check("idle_run", 32'(timer_run), 32'd1);
    check("idle_aen", 32'(aen), 32'h3F);
    check("idle_dp", 32'(dp_en), 32'h14);
    check("idle_load", 32'(load_en), 32'd0);

    // Full edit pass with wraps on every field.
    cur_hms = 32'h00235958;
    n0 = load_cnt;
    press(1, 0, 0);
    check("edit_run_low", 32'(timer_run), 32'd0);
    press(0, 1, 0); press(1, 0, 0);
    press(0, 1, 0); press(1, 0, 0);
    press(0, 1, 0); press(1, 0, 0);
    check("edit_load_cnt", 32'(load_cnt - n0), 32'd1);
    check("edit_load_hms", last_load, 32'h00000059);
    check("edit_run_high", 32'(timer_run), 32'd1);

    // Bouncing inc gives one press; short glitch gives none.
    cur_hms = 32'h00000000;
    n0 = load_cnt;
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      btn_inc = ~btn_inc;
      repeat (2) @(negedge clk_100m);
    end
    btn_inc = 1'b1;
    repeat (10) @(negedge clk_100m);
    btn_inc = 1'b0;
    repeat (10) @(negedge clk_100m);
    btn_inc = 1'b1;
    repeat (3) @(negedge clk_100m);
    btn_inc = 1'b0;
    repeat (10) @(negedge clk_100m);
    press(1, 0, 0);
    check("bounce_load_cnt", 32'(load_cnt - n0), 32'd1);
    check("bounce_load_hms", last_load, 32'h00000001);

    // Blink period in SET_MM, then dec wraps 00 -> 59.
    cur_hms = 32'h00120034;
    n0 = load_cnt;
    press(1, 0, 0); press(1, 0, 0);
    wait_aen("blink_vis", 8'h3F);
    wait_aen("blink_off", 8'h33);
    run_len(8'h33, len);
    check("blink_off_len", 32'(len), 32'd8);
    run_len(8'h3F, len);
    check("blink_on_len", 32'(len), 32'd8);
    press(0, 0, 1);
    press(1, 0, 0); press(1, 0, 0);
    check("mm_dec_load_hms", last_load, 32'h00125934);

    // Mode with inc: mode wins; inc with dec: nothing.
    cur_hms = 32'h00081530;
    press(1, 0, 0);
    press(1, 1, 0);
    press(0, 1, 1);
    press(1, 0, 0);
    n0 = load_cnt;
    press(1, 0, 0);
    check("simul_load_cnt", 32'(load_cnt - n0), 32'd1);
    check("simul_load_hms", last_load, 32'h00081530);

    // Table of single-field edits.
    for (int i = 0; i < 12; i++) begin
      cur_hms = tbl[i].cur;
      n0 = load_cnt;
      press(1, 0, 0);
      for (int k = 0; k < tbl[i].field; k++) press(1, 0, 0);
      press(0, tbl[i].up, !tbl[i].up);
      for (int k = tbl[i].field; k < 3; k++) press(1, 0, 0);
      check($sformatf("tbl%0d_load_cnt", i), 32'(load_cnt - n0), 32'd1);
      check($sformatf("tbl%0d_load_hms", i), last_load, tbl[i].exp);
    end

    // Timeout abandons the edit.
    cur_hms = 32'h00111111;
    n0 = load_cnt;
    press(1, 0, 0);
    press(0, 1, 0);
    check("tmo_run_low", 32'(timer_run), 32'd0);
    repeat (TMO + 20) @(negedge clk_100m);
    check("tmo_run_high", 32'(timer_run), 32'd1);
    check("tmo_no_load", 32'(load_cnt - n0), 32'd0);

    // Reset in the middle of an edit.
    n0 = load_cnt;
    press(1, 0, 0);
    press(0, 1, 0);
    @(negedge clk_100m);
    #2 rst_n = 1'b0;
    #1;
    check("rst_run", 32'(timer_run), 32'd1);
    check("rst_aen", 32'(aen), 32'h3F);
    check("rst_load", 32'(load_en), 32'd0);
    check("rst_load_hms", load_hms, 32'h0);
    repeat (3) @(negedge clk_100m);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk_100m);
    check("rst_no_load", 32'(load_cnt - n0), 32'd0);
    check("rst_run_after", 32'(timer_run), 32'd1);

    // Random button activity against the model.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 1) == 1)
        cur_hms = $urandom();
      else
        cur_hms = {8'h00, to_bcd(int'($urandom_range(0, 23))),
                   to_bcd(int'($urandom_range(0, 59))), to_bcd(int'($urandom_range(0, 59)))};
      @(negedge clk_100m);
      btn_mode = ($urandom_range(0, 2) == 0);
      btn_inc  = ($urandom_range(0, 1) == 0);
      btn_dec  = ($urandom_range(0, 2) == 0);
      repeat ($urandom_range(1, 12)) @(negedge clk_100m);
      btn_mode = 0; btn_inc = 0; btn_dec = 0;
      repeat ($urandom_range(1, 12)) @(negedge clk_100m);
    end
    repeat (20) @(negedge clk_100m);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
